// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - RV32I execute-stage ALU with decode, output register and optional iterative mul/div
// Optional feature macro: ALU_MULDIV_EN (M-extension mul/div, XLEN-cycle iterative engine).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kills in-flight mul/div and the output register
//   in_valid/in_ready     input handshake; in_alu_op, in_funct3, in_funct7, in_a, in_b
//   out_valid/out_ready   output handshake; out_result, out_illegal
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_alu_op,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);
    localparam int SW = $clog2(XLEN);

    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] base_res;
    logic            illegal;
    logic            op_ok;
    logic            alt;
    logic            is_md;
    logic            md_done;
    logic            idle;
    logic [XLEN-1:0] md_res;
    logic            started;
    logic            accept;

    // Decode and single-cycle datapath
    always_comb begin
        shamt    = in_b[SW-1:0];
        base_res = '0;
        op_ok    = 1'b1;
        alt      = 1'b0;
        is_md    = 1'b0;
        illegal  = 1'b0;
        case (in_alu_op)
            3'b000: begin
                case (in_funct7)
                    7'b0000000: alt = 1'b0;
                    7'b0100000: begin
                        alt   = 1'b1;
                        op_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b101);
                    end
`ifdef ALU_MULDIV_EN
                    7'b0000001: is_md = 1'b1;
`endif
                    default:    op_ok = 1'b0;
                endcase
            end
            3'b001: begin
                // funct7[5] only matters for shifts: selects srai, and must be clear for slli
                alt = (in_funct3 == 3'b101) && in_funct7[5];
                if ((in_funct3 == 3'b001) && in_funct7[5])
                    op_ok = 1'b0;
            end
            default: alt = 1'b0;
        endcase

        case (in_alu_op)
            3'b000, 3'b001: begin
                case (in_funct3)
                    3'b000: base_res = alt ? (in_a - in_b) : (in_a + in_b);
                    3'b001: base_res = in_a << shamt;
                    3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
                    3'b011: base_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
                    3'b100: base_res = in_a ^ in_b;
                    3'b101: base_res = alt ? XLEN'($signed(in_a) >>> shamt) : (in_a >> shamt);
                    3'b110: base_res = in_a | in_b;
                    default: base_res = in_a & in_b;
                endcase
            end
            3'b101:         base_res = in_b;
            3'b100, 3'b111: base_res = in_a + XLEN'(4);
            default:        base_res = in_a + in_b;
        endcase

        if (!op_ok || is_md)
            base_res = '0;
        illegal = !op_ok;
    end

    assign in_ready = started && !flush && idle && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;

    logic [SW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_nx, prod;
    logic [XLEN-1:0]   opd, a_keep, a_mag, b_mag, q_fix, r_fix;
    logic [XLEN:0]     msum, shifted, rdiff;
    logic [2:0]        f3_q;
    logic              neg_q, neg_r, div0, a_sgn, b_sgn, ge;

    assign idle = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        md_done  = 1'b0;
        case (state)
            IDLE: if (accept && is_md) state_nx = BUSY;
            BUSY: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (cnt == SW'(XLEN-1)) begin
                    state_nx = IDLE;
                    md_done  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand signedness: mulh signs both, mulhsu signs a only; div/rem signed when funct3[0]=0
    always_comb begin
        a_sgn = in_funct3[2] ? !in_funct3[0] : (in_funct3[1:0] == 2'b01 || in_funct3[1:0] == 2'b10);
        b_sgn = in_funct3[2] ? !in_funct3[0] : (in_funct3[1:0] == 2'b01);
        a_mag = (a_sgn && in_a[XLEN-1]) ? -in_a : in_a;
        b_mag = (b_sgn && in_b[XLEN-1]) ? -in_b : in_b;
    end

    // One iteration: acc = {hi, lo}; multiply adds opd into hi when lo[0] is set and
    // shifts right; divide shifts the dividend into the remainder and subtracts if it fits.
    always_comb begin
        msum    = '0;
        shifted = '0;
        rdiff   = '0;
        ge      = 1'b0;
        if (!f3_q[2]) begin
            msum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
            acc_nx = {msum, acc[XLEN-1:1]};
        end else begin
            shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
            ge      = shifted >= {1'b0, opd};
            rdiff   = shifted - {1'b0, opd};
            acc_nx  = {(ge ? rdiff[XLEN-1:0] : shifted[XLEN-1:0]), acc[XLEN-2:0], ge};
        end
    end

    always_comb begin
        prod  = neg_q ? -acc_nx : acc_nx;
        q_fix = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        r_fix = neg_r ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        if (!f3_q[2])
            md_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (div0)
            md_res = f3_q[1] ? a_keep : '1;
        else
            md_res = f3_q[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opd    <= '0;
            a_keep <= '0;
            f3_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else if (accept && is_md) begin
            cnt    <= '0;
            f3_q   <= in_funct3;
            a_keep <= in_a;
            div0   <= (in_b == '0);
            neg_q  <= (a_sgn && in_a[XLEN-1]) ^ (b_sgn && in_b[XLEN-1]);
            neg_r  <= a_sgn && in_a[XLEN-1];
            if (!in_funct3[2]) begin
                acc <= {{XLEN{1'b0}}, b_mag};
                opd <= a_mag;
            end else begin
                acc <= {{XLEN{1'b0}}, a_mag};
                opd <= b_mag;
            end
        end else if (state == BUSY) begin
            cnt <= flush ? '0 : cnt + SW'(1);
            acc <= acc_nx;
        end
    end
`else
    assign idle    = 1'b1;
    assign md_done = 1'b0;
    assign md_res  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_illegal <= 1'b0;
        end else begin
            started <= 1'b1;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (md_done) begin
                out_valid   <= 1'b1;
                out_result  <= md_res;
                out_illegal <= 1'b0;
            end else if (accept && !is_md) begin
                out_valid   <= 1'b1;
                out_result  <= base_res;
                out_illegal <= illegal;
            end else if (accept || out_ready) begin
                // mul/div accepted (old result drains meanwhile) or plain drain
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_alu_op = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Offer one op, wait (bounded) for acceptance; returns 1 ns after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_alu_op = op; in_funct3 = f3; in_funct7 = f7; in_a = a; in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({in_ready, out_valid, out_illegal} !== 3'b000 || out_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs ready=%0b valid=%0b ill=%0b res=%h required 0", in_ready, out_valid, out_illegal, out_result);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early in_ready=%0b required 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_late in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_base_ops;
        vec_t v[$];
        v.push_back('{3'b000, 3'b000, 7'h00, 32'd5,         32'd7,         32'd12,        1'b0}); // add
        v.push_back('{3'b000, 3'b000, 7'h20, 32'd5,         32'd7,         32'hFFFFFFFE,  1'b0}); // sub
        v.push_back('{3'b001, 3'b000, 7'h20, 32'd1,         32'd1,         32'd2,         1'b0}); // addi
        v.push_back('{3'b001, 3'b101, 7'h20, 32'h80000000,  32'd4,         32'hF8000000,  1'b0}); // srai
        v.push_back('{3'b001, 3'b010, 7'h00, 32'hFFFFFFFF,  32'd0,         32'd1,         1'b0}); // slti
        v.push_back('{3'b001, 3'b011, 7'h00, 32'hFFFFFFFF,  32'd0,         32'd0,         1'b0}); // sltiu
        v.push_back('{3'b111, 3'b000, 7'h00, 32'h100,       32'h55,        32'h104,       1'b0}); // jal
        v.push_back('{3'b101, 3'b000, 7'h00, 32'h77,        32'h12345000,  32'h12345000,  1'b0}); // lui
        v.push_back('{3'b000, 3'b111, 7'h20, 32'hFF,        32'h0F,        32'd0,         1'b1}); // bad R alt
        v.push_back('{3'b000, 3'b001, 7'h00, 32'd1,         32'd33,        32'd2,         1'b0}); // sll uses low 5 bits
        v.push_back('{3'b000, 3'b101, 7'h00, 32'h80000000,  32'd31,        32'd1,         1'b0}); // srl
        v.push_back('{3'b000, 3'b101, 7'h20, 32'h80000000,  32'd1,         32'hC0000000,  1'b0}); // sra
        v.push_back('{3'b001, 3'b001, 7'h20, 32'd1,         32'd1,         32'd0,         1'b1}); // slli f7[5]=1
        v.push_back('{3'b000, 3'b010, 7'h00, 32'h7FFFFFFF,  32'h80000000,  32'd0,         1'b0}); // slt
        v.push_back('{3'b000, 3'b011, 7'h00, 32'h7FFFFFFF,  32'h80000000,  32'd1,         1'b0}); // sltu
        v.push_back('{3'b000, 3'b100, 7'h00, 32'hF0F0,      32'h0FF0,      32'hFF00,      1'b0}); // xor
        v.push_back('{3'b001, 3'b110, 7'h00, 32'hF000,      32'h000F,      32'hF00F,      1'b0}); // ori
        v.push_back('{3'b000, 3'b111, 7'h00, 32'hF0F0,      32'h0FF0,      32'h00F0,      1'b0}); // and
        v.push_back('{3'b010, 3'b010, 7'h00, 32'h1000,      32'hFFFFFFFC,  32'hFFC,       1'b0}); // load
        v.push_back('{3'b110, 3'b000, 7'h00, 32'h10,        32'h2000,      32'h2010,      1'b0}); // auipc
        v.push_back('{3'b100, 3'b000, 7'h00, 32'h200,       32'h8,         32'h204,       1'b0}); // jalr
        v.push_back('{3'b000, 3'b000, 7'h40, 32'd5,         32'd7,         32'd0,         1'b1}); // bad funct7
`ifndef ALU_MULDIV_EN
        v.push_back('{3'b000, 3'b000, 7'h01, 32'd3,         32'd4,         32'd0,         1'b1}); // mul w/o M
`endif
        out_ready = 1'b1;
        foreach (v[i]) begin
            send(v[i].op, v[i].f3, v[i].f7, v[i].a, v[i].b);
            checks++;
            if (out_valid !== 1'b1 || out_result !== v[i].res || out_illegal !== v[i].ill) begin
                errors++;
                $display("FAIL base_vec%0d valid=%0b res=%h ill=%0b required 1 %h %0b",
                         i, out_valid, out_result, out_illegal, v[i].res, v[i].ill);
            end
        end
    endtask

    task automatic test_back_pressure;
        out_ready = 1'b1;
        send(3'b000, 3'b000, 7'h00, 32'd1, 32'd1);
        out_ready = 1'b0;
        in_alu_op = 3'b000; in_funct3 = 3'b000; in_funct7 = 7'h00;
        in_a = 32'd10; in_b = 32'd20; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'd2 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d valid=%0b res=%h ready=%0b required 1 2 0", c, out_valid, out_result, in_ready);
            end
        end
        out_ready = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_ready in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd30) begin
            errors++;
            $display("FAIL drain_accept valid=%0b res=%h required 1 1e", out_valid, out_result);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_flush_output;
        out_ready = 1'b1;
        send(3'b000, 3'b000, 7'h00, 32'd3, 32'd4);
        out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1;
        in_alu_op = 3'b000; in_funct3 = 3'b000; in_funct7 = 7'h00;
        in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_ready in_ready=%0b required 0", in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clears valid=%0b required 0", out_valid);
        end
    endtask

`ifdef ALU_MULDIV_EN
    task automatic test_muldiv;
        vec_t v[$];
        int n;
        v.push_back('{3'b000, 3'b000, 7'h01, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0}); // mul
        v.push_back('{3'b000, 3'b011, 7'h01, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0}); // mulhu
        v.push_back('{3'b000, 3'b001, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0}); // mulh
        v.push_back('{3'b000, 3'b010, 7'h01, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0}); // mulhsu
        v.push_back('{3'b000, 3'b100, 7'h01, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0}); // div /0
        v.push_back('{3'b000, 3'b110, 7'h01, 32'd7,        32'd0,        32'd7,        1'b0}); // rem /0
        v.push_back('{3'b000, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0}); // overflow
        v.push_back('{3'b000, 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0}); // overflow rem
        v.push_back('{3'b000, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0}); // -7/2
        v.push_back('{3'b000, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0}); // -7%2
        v.push_back('{3'b000, 3'b101, 7'h01, 32'd100,      32'd7,        32'd14,       1'b0}); // divu
        v.push_back('{3'b000, 3'b111, 7'h01, 32'd100,      32'd7,        32'd2,        1'b0}); // remu
        out_ready = 1'b1;
        foreach (v[i]) begin
            send(v[i].op, v[i].f3, v[i].f7, v[i].a, v[i].b);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL md_busy%0d valid=%0b ready=%0b required 0 0", i, out_valid, in_ready);
            end
            n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n !== 32 || out_result !== v[i].res || out_illegal !== v[i].ill) begin
                errors++;
                $display("FAIL md_vec%0d latency=%0d res=%h ill=%0b required 32 %h %0b",
                         i, n, out_result, out_illegal, v[i].res, v[i].ill);
            end
        end
    endtask

    task automatic test_flush_busy;
        logic seen = 1'b0;
        out_ready = 1'b1;
        send(3'b000, 3'b000, 7'h01, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy ready=%0b valid=%0b required 1 0", in_ready, out_valid);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_no_result seen=%0b required 0", seen);
        end
    endtask
`endif

    task automatic test_reset_mid;
`ifdef ALU_MULDIV_EN
        out_ready = 1'b1;
        send(3'b000, 3'b000, 7'h01, 32'd6, 32'd7);
        repeat (5) @(posedge clk);
`else
        out_ready = 1'b1;
        send(3'b000, 3'b000, 7'h00, 32'd3, 32'd4);
        out_ready = 1'b0;
        @(posedge clk);
`endif
        #2; rst_n = 1'b0; #1;
        checks++;
        if ({in_ready, out_valid, out_illegal} !== 3'b000 || out_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid ready=%0b valid=%0b ill=%0b res=%h required 0", in_ready, out_valid, out_illegal, out_result);
        end
        out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        send(3'b000, 3'b000, 7'h00, 32'd2, 32'd3);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd5) begin
            errors++;
            $display("FAIL after_reset valid=%0b res=%h required 1 5", out_valid, out_result);
        end
    endtask

    initial begin
        test_reset();
        test_base_ops();
        test_back_pressure();
        test_flush_output();
`ifdef ALU_MULDIV_EN
        test_muldiv();
        test_flush_busy();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
